// File: rtl/spi_reg_master.sv
// SPI master for the register-bank DAC slaves: takes one write or read-back
// command per handshake, shifts it out MSB first on sclk/cs/mosi, and pulses
// done once the frame and its trailing chip-select gap are complete.
module spi_reg_master #(
  parameter int CLK_DIV = 4,  // sclk half-period in clk cycles (1..255)
  parameter int GAP     = 2   // sclk periods with cs high after a frame / on flush (1..15)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic       cmd_slv,
  input  logic [2:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_N    = 4'(GAP);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [3:0]  gap_q, gap_d;
  logic [13:0] shift_q, shift_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        tick;
  logic [13:0] word_c;

  // A phase (half sclk period) ends when the divider reaches zero.
  assign tick = (div_q == 8'd0);

  // Frame word left-aligned in 14 bits; reads carry slave/register only.
  // The trailing 0 is the dummy bit whose edge lets the slave update its DAC.
  assign word_c = cmd_wr ? {1'b1, cmd_slv, cmd_reg, cmd_data, 1'b0}
                         : {1'b0, cmd_slv, cmd_reg, 1'b0, 8'h00};

  // Next-state logic: phase sequencing for flush, setup, shift and gap.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    // Divider holds its reload value in IDLE so SETUP starts a full phase.
    if (state_q != ST_IDLE && !tick) div_d = div_q - 8'd1;
    else                             div_d = DIV_LAST;

    case (state_q)
      ST_FLUSH: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (gap_q == GAP_LAST) begin
              state_d = ST_IDLE;
              ready_d = 1'b1;
              gap_d   = 4'd0;
            end else begin
              gap_d = gap_q + 4'd1;
            end
          end
        end
      end
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d = ST_SETUP;
          ready_d = 1'b0;
          cs_d    = 1'b0;
          bit_d   = cmd_wr ? 4'd13 : 4'd5;
          mosi_d  = word_c[13];
          shift_d = {word_c[12:0], 1'b0};
        end
      end
      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // mosi only moves on the falling edge, keeping it stable at each rise.
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              cs_d    = 1'b1;
              mosi_d  = 1'b0;
              gap_d   = 4'd0;
              state_d = ST_GAP;
            end else begin
              mosi_d  = shift_q[13];
              shift_d = {shift_q[12:0], 1'b0};
              bit_d   = bit_q - 4'd1;
            end
          end
        end
      end
      ST_GAP: begin
        // Low phase of the last bit, then GAP full periods with cs high.
        if (tick) begin
          if (!sclk_q) begin
            if (gap_q == GAP_N) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              ready_d = 1'b1;
              gap_d   = 4'd0;
            end else begin
              sclk_d = 1'b1;
            end
          end else begin
            sclk_d = 1'b0;
            gap_d  = gap_q + 4'd1;
          end
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  // Control and bus registers; reset drops the bus to idle immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FLUSH;
      div_q   <= DIV_LAST;
      bit_q   <= 4'd0;
      gap_q   <= 4'd0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Shift data needs no reset: it is always loaded before it is used.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign sclk      = sclk_q;
  assign cs        = cs_q;
  assign mosi      = mosi_q;
  assign cmd_ready = ready_q;
  assign done      = done_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: a recorder pushes the expected frame for every
// accepted command, a bus monitor decodes the SPI frame and checks it (plus
// handshake-to-done latency) when done pulses.
module tb_spi_reg_master;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_wr = 1'b0;
  logic       cmd_slv = 1'b0;
  logic [2:0] cmd_reg = 3'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       sclk, cs, mosi, done;

  spi_reg_master #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_slv(cmd_slv), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .sclk(sclk), .cs(cs), .mosi(mosi), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int word;  // frame bits as an integer, first bit most significant
    int len;   // number of bits in the frame
    int lat;   // handshake edge to done edge, in clk cycles
    int hs;    // edge index of the handshake
  } frame_exp_t;

  frame_exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issued = 0;
  int hs_count = 0;
  int last_on_done = 0;
  bit mon_en = 1'b0;
  int mon_nbits = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: frame content and duration straight from the frame rules.
  function automatic frame_exp_t model(input bit wr, input bit slv, input bit [2:0] rg,
                                       input bit [7:0] d);
    frame_exp_t e;
    if (wr) begin
      e.len  = 14;
      e.word = 8192 + int'(slv) * 4096 + int'(rg) * 512 + int'(d) * 2;
    end else begin
      e.len  = 6;
      e.word = int'(slv) * 16 + int'(rg) * 2;
    end
    e.lat = CLK_DIV * (1 + 2 * e.len + 2 * GAP);
    e.hs  = 0;
    return e;
  endfunction

  // Edge counter: value after an edge is that edge's index.
  always @(posedge clk) cyc <= cyc + 1;

  // Recorder: every accepted command pushes its expected frame.
  always @(posedge clk) begin
    frame_exp_t e;
    if (reset_n && mon_en && cmd_valid && cmd_ready) begin
      e = model(cmd_wr, cmd_slv, cmd_reg, cmd_data);
      e.hs = cyc + 1;
      sb.push_back(e);
      hs_count++;
      last_on_done = int'(done);
    end
  end

  // Bus monitor: decodes frames and checks them against the scoreboard on done.
  int  rises = 0;
  int  got = 0;
  int  fr_word = 0;
  int  fr_len = 0;
  bit  in_frame = 1'b0;
  bit  stable_ok = 1'b1;
  bit  have_frame = 1'b0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
  always @(negedge clk) begin
    frame_exp_t e;
    if (!reset_n || !mon_en) begin
      in_frame = 1'b0; mon_nbits = 0; got = 0; rises = 0;
      stable_ok = 1'b1; have_frame = 1'b0;
    end else begin
      if (!cs && prev_cs) begin
        chk("gap_rises_before_frame", rises, GAP);
        in_frame = 1'b1; mon_nbits = 0; got = 0; stable_ok = 1'b1;
      end else if (in_frame && mosi != prev_mosi && !(prev_sclk && !sclk)) begin
        stable_ok = 1'b0;
      end
      if (sclk && !prev_sclk) begin
        if (!cs) begin
          got = got * 2 + int'(mosi);
          mon_nbits++;
        end else begin
          rises++;
        end
      end
      if (cs && !prev_cs && in_frame) begin
        in_frame = 1'b0; fr_word = got; fr_len = mon_nbits;
        have_frame = 1'b1; rises = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done pulsed with no command pending (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("frame_seen", int'(have_frame), 1);
          chk("frame_bits", fr_word, e.word);
          chk("frame_len", fr_len, e.len);
          chk("done_latency", cyc - e.hs, e.lat);
          chk("mosi_stable", int'(stable_ok), 1);
          chk("ready_on_done", int'(cmd_ready), 1);
        end
        have_frame = 1'b0;
      end
    end
    prev_sclk = sclk; prev_cs = cs; prev_mosi = mosi;
  end

  // Releases reset (called at a negedge) and measures the flush sequence.
  task automatic flush_check();
    int n = 0;
    int r = 0;
    int csl = 0;
    logic ps;
    reset_n = 1'b1;
    ps = sclk;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (sclk && !ps) r++;
      ps = sclk;
      if (!cs) csl = 1;
      if (cmd_ready) break;
    end
    chk("flush_cycles", n, 2 * GAP * CLK_DIV);
    chk("flush_sclk_rises", r, GAP);
    chk("flush_cs_low", csl, 0);
    @(negedge clk);
  endtask

  // Presents a command from a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit wr, input bit slv, input bit [2:0] rg, input bit [7:0] d,
                       input bit hold);
    int n = 0;
    cmd_wr = wr; cmd_slv = slv; cmd_reg = rg; cmd_data = d;
    cmd_valid = 1'b1;
    issued++;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: cmd_ready stayed %0d, required 1", cmd_ready);
      cmd_valid = 1'b0;
      issued--;
    end else begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: cmd_ready stayed %0d, required 1", cmd_ready);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    bit h;
    int n;
    // Reset values
    #2 reset_n = 1'b0;
    #1;
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_cs", int'(cs), 1);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_done", int'(done), 0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    flush_check();

    // Directed write and read
    issue(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0);
    wait_ready();
    repeat (3) @(negedge clk);
    issue(1'b0, 1'b0, 3'd6, 8'h00, 1'b0);
    wait_ready();
    repeat (2) @(negedge clk);

    // Back-to-back: second handshake must land on the done cycle
    issue(1'b1, 1'b0, 3'd5, 8'h3C, 1'b1);
    issue(1'b0, 1'b1, 3'd2, 8'hFF, 1'b0);
    chk("b2b_on_done", last_on_done, 1);
    wait_ready();

    // Busy: new commands while shifting must be ignored
    issue(1'b1, 1'b1, 3'd7, 8'h5A, 1'b0);
    repeat (40) begin
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_wr    = 1'($urandom_range(0, 1));
      cmd_slv   = 1'($urandom_range(0, 1));
      cmd_reg   = 3'($urandom_range(0, 7));
      cmd_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ready();

    // Random commands, some back-to-back
    for (int i = 0; i < 12; i++) begin
      h = ($urandom_range(0, 2) == 0) && (i != 11);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)), h);
      if (!h) begin
        wait_ready();
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
    end

    // Mid-frame reset during bit 8 of a write
    issue(1'b1, 1'b0, 3'd4, 8'hC3, 1'b0);
    n = 0;
    while (mon_nbits < 8 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit8", mon_nbits, 8);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_cs", int'(cs), 1);
    chk("midrst_sclk", int'(sclk), 0);
    chk("midrst_mosi", int'(mosi), 0);
    chk("midrst_ready", int'(cmd_ready), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    flush_check();
    issue(1'b0, 1'b0, 3'd4, 8'h00, 1'b0);
    wait_ready();
    repeat (4) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    chk("handshake_count", hs_count, issued);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

Upstream SPI master that drives the register-bank DAC slaves in this design. It accepts one register write or read-back command per handshake from the system controller, serialises it onto `sclk`/`cs`/`mosi` in the slave frame format, and signals completion. The same bus is shared by slave address 0 and slave address 1.

## Interface
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles; legal range 1..255.
- `GAP`, default 2: full `sclk` periods with `cs` high after each frame, and for the post-reset flush; legal range 1..15.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_wr` in 1: 1 selects write, 0 selects read-back (DAC update only).
- `cmd_slv` in 1: target slave address.
- `cmd_reg` in 3: target register index.
- `cmd_data` in 8: write data; ignored for reads.
- `sclk` out 1: SPI clock; idles low.
- `cs` out 1: chip select, active low; idles high.
- `mosi` out 1: serial data; idles 0.
- `done` out 1: one-cycle pulse at end of frame plus gap.

## Operation
- Reset (asynchronous, immediate): `sclk`=0, `cs`=1, `mosi`=0, `cmd_ready`=0, `done`=0; state FLUSH.
- FLUSH: toggle `sclk` for GAP full periods with `cs`=1, so slaves resynchronise their bit counters. Then enter IDLE. `done` is not pulsed.
- IDLE: `cmd_ready`=1. When `cmd_valid && cmd_ready` on a clk edge:
  - Latch all command fields.
  - Build the shift word, sent MSB first:
    - Write: 14 bits `{1, slv, reg[2], reg[1], reg[0], data[7:0], 0}`.
    - Read: 6 bits `{0, slv, reg[2:0], 0}`.
  - The trailing 0 is a dummy bit. It gives the slave the edge on which it updates its DAC output.
  - Go to SETUP.
- SETUP: `cs`=0, `mosi`=bit 0, `sclk`=0 for CLK_DIV cycles, then SHIFT.
- SHIFT:
  - Each bit is `sclk` high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - `mosi` changes only on `clk` cycles where `sclk` falls, so it is stable across every rising edge.
  - After the high phase of the last bit, `sclk` falls, `cs`=1 and `mosi`=0 in the same cycle; go to GAP.
- GAP: GAP full `sclk` periods with `cs`=1. Then `done`=1 for one cycle, `cmd_ready`=1 in that same cycle, and return to IDLE.
- `cmd_ready`=0 in SETUP, SHIFT, GAP and FLUSH. `cmd_valid` in those states is ignored, with no queuing.
- Counters:
  - 8-bit divider counter.
  - 4-bit bit counter; the bit length is 14 or 6.
  - 4-bit gap counter.
  - No other arithmetic. The divider reloads at every phase change.

## Timing
- Handshake at edge T: `cs` goes low and bit 0 appears on `mosi` in the cycle after T.
- First `sclk` rise: CLK_DIV cycles after `cs` falls.
- Handshake to `done`: CLK_DIV·(1 + 2N + 2·GAP) cycles, where N is 14 for a write and 6 for a read.
  - Defaults, write: 4·(1+28+4) = 132 cycles.
  - Defaults, read: 4·(1+12+4) = 68 cycles.
- Back-to-back: with `cmd_valid` held high, the next command is accepted on the `done` cycle. `cs` is then high for exactly GAP `sclk` periods between frames.
- `sclk` duty cycle is exactly 50%, with period 2·CLK_DIV `clk` cycles.
- `reset_n` asserted mid-frame aborts the frame immediately; outputs take their idle values asynchronously and FLUSH runs after release. A partial write never reaches the register array, because the slave writes data bits only on their own edges and the frame is cut by the flush.
- FLUSH after release: GAP·2·CLK_DIV cycles until `cmd_ready` rises.

## Test plan
- **Reset release** (defaults): no `cs` low, 2 `sclk` rising edges, `cmd_ready` rises 16 cycles after `reset_n` rises.
- **Write slv=1 reg=3 data=0xA5**: `mosi` at the 14 rising edges is 1,1,0,1,1,1,0,1,0,0,1,0,1,0. `done` comes 132 cycles after the handshake. A slave at address 1 then outputs DAC 0xA5; a slave at address 0 keeps its output unchanged.
- **Read slv=0 reg=6**: `mosi` is 0,0,1,1,0,0 over 6 rising edges. `done` comes at 68 cycles. The slave at address 0 outputs DAC 0x16 (its default).
- **Back-to-back** write then read with `cmd_valid` held: the second handshake lands on the `done` cycle, with exactly 2 `sclk` rises while `cs` is high in between.
- **Busy**: `cmd_valid` toggled with new fields during SHIFT is ignored; the transmitted bits match the latched command.
- **Mid-frame reset**: `reset_n` is pulled low at bit 8 of a write. `cs`=1 and `sclk`=0 in the same cycle. After FLUSH, a read of the same register returns its old value.
